// File: rtl/ping_pong_sequencer_pkg.sv
// Shared definitions for the ping-pong counter sequencer: state encoding,
// counter data width and the packed layout of one program-table entry.
package ping_pong_sequencer_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  // Entry layout from LSB: max, min, len, last.
  localparam int MAX_LSB = 0;
  localparam int MIN_LSB = DATA_W;
  localparam int LEN_LSB = 2 * DATA_W;

  function automatic int seg_w(input int len_w);
    return 2 * DATA_W + len_w + 1;
  endfunction

endpackage

// File: rtl/ping_pong_seg_table.sv
// Program table: NUM_SEG segment entries, synchronous write, combinational
// read of the entry selected by the sequencer's active segment index.
module ping_pong_seg_table
  import ping_pong_sequencer_pkg::*;
#(
  parameter  int NUM_SEG = 4,
  parameter  int LEN_W   = 8,
  localparam int ADDR_W  = $clog2(NUM_SEG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_max,
  input  logic [DATA_W-1:0] wr_min,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic              wr_last,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_max,
  output logic [DATA_W-1:0] rd_min,
  output logic [LEN_W-1:0]  rd_len,
  output logic              rd_last
);

  localparam int SEG_W = seg_w(LEN_W);
  localparam logic [SEG_W-1:0] CLEAR_ENTRY = {1'b1, {(SEG_W-1){1'b0}}};

  logic [SEG_W-1:0] mem [NUM_SEG];

  // NOTE: this table is deliberately reset; a cleared entry (len=0, last=1)
  // makes a start on an unprogrammed table finish immediately and safely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SEG; i++) mem[i] <= CLEAR_ENTRY;
    end else if (we) begin
      mem[wr_addr] <= {wr_last, wr_len, wr_min, wr_max};
    end
  end

  assign rd_max  = mem[rd_addr][MAX_LSB +: DATA_W];
  assign rd_min  = mem[rd_addr][MIN_LSB +: DATA_W];
  assign rd_len  = mem[rd_addr][LEN_LSB +: LEN_W];
  assign rd_last = mem[rd_addr][SEG_W-1];

endmodule

// File: rtl/ping_pong_sequencer.sv
// Steps one ping-pong counter through a stored program of segments: reload
// with new bounds, run for len enabled cycles, forward flip requests.
module ping_pong_sequencer
  import ping_pong_sequencer_pkg::*;
#(
  parameter  int NUM_SEG = 4,
  parameter  int LEN_W   = 8,
  localparam int ADDR_W  = $clog2(NUM_SEG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_max,
  input  logic [DATA_W-1:0] cfg_min,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_last,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic              flip_req,
  output logic              cnt_rst_n,
  output logic              cnt_enable,
  output logic              cnt_flip,
  output logic [DATA_W-1:0] cnt_max,
  output logic [DATA_W-1:0] cnt_min,
  output logic [ADDR_W-1:0] seg_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic [LEN_W-1:0]  remaining;
  logic              flip_pend;
  logic [DATA_W-1:0] ent_max;
  logic [DATA_W-1:0] ent_min;
  logic [LEN_W-1:0]  ent_len;
  logic              ent_last;

  ping_pong_seg_table #(
    .NUM_SEG (NUM_SEG),
    .LEN_W   (LEN_W)
  ) u_seg_table (
    .clk     (clk),
    .rst     (rst),
    .we      (cfg_we),
    .wr_addr (cfg_addr),
    .wr_max  (cfg_max),
    .wr_min  (cfg_min),
    .wr_len  (cfg_len),
    .wr_last (cfg_last),
    .rd_addr (seg_idx),
    .rd_max  (ent_max),
    .rd_min  (ent_min),
    .rd_len  (ent_len),
    .rd_last (ent_last)
  );

  // NOTE: all state and outputs use non-blocking assignments so every branch
  // reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      remaining  <= '0;
      flip_pend  <= 1'b0;
      cnt_rst_n  <= 1'b0;
      cnt_enable <= 1'b0;
      cnt_flip   <= 1'b0;
      cnt_max    <= '0;
      cnt_min    <= '0;
      seg_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else if (abort && state != S_IDLE) begin
      state      <= S_IDLE;
      flip_pend  <= 1'b0;
      cnt_rst_n  <= 1'b1;
      cnt_enable <= 1'b0;
      cnt_flip   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      cnt_rst_n  <= 1'b1;
      cnt_enable <= 1'b0;
      cnt_flip   <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !abort && !busy) begin
            state   <= S_LOAD;
            seg_idx <= '0;
            busy    <= 1'b1;
            err     <= 1'b0;
          end
        end
        S_LOAD: begin
          cnt_rst_n <= 1'b0;
          cnt_max   <= ent_max;
          cnt_min   <= ent_min;
          remaining <= ent_len;
          if (ent_max <= ent_min) begin
            err   <= 1'b1;
            state <= S_NEXT;
          end else if (ent_len == '0) begin
            state <= S_NEXT;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // A flip is only emitted alongside an enabled cycle; while paused it waits.
          if (!pause) begin
            cnt_enable <= 1'b1;
            cnt_flip   <= flip_pend | flip_req;
            flip_pend  <= 1'b0;
            remaining  <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= S_NEXT;
          end else begin
            flip_pend <= flip_pend | flip_req;
          end
        end
        S_NEXT: begin
          if (ent_last || seg_idx == ADDR_W'(NUM_SEG - 1)) begin
            state <= S_DONE;
          end else begin
            seg_idx <= seg_idx + ADDR_W'(1);
            state   <= S_LOAD;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ping_pong_sequencer.sv
// Self-checking bench for ping_pong_sequencer: a reference model of the
// program table predicts load/done/abort events into a scoreboard queue.
module tb_ping_pong_sequencer;

  localparam int NUM_SEG = 4;
  localparam int LEN_W   = 8;
  localparam int ADDR_W  = 2;

  localparam int EV_LOAD  = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ABORT = 2;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_we = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [3:0]        cfg_max = '0;
  logic [3:0]        cfg_min = '0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              cfg_last = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              pause = 1'b0;
  logic              flip_req = 1'b0;
  logic              cnt_rst_n;
  logic              cnt_enable;
  logic              cnt_flip;
  logic [3:0]        cnt_max;
  logic [3:0]        cnt_min;
  logic [ADDR_W-1:0] seg_idx;
  logic              busy;
  logic              done;
  logic              err;

  ping_pong_sequencer #(.NUM_SEG(NUM_SEG), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_max(cfg_max), .cfg_min(cfg_min), .cfg_len(cfg_len), .cfg_last(cfg_last),
    .start(start), .abort(abort), .pause(pause), .flip_req(flip_req),
    .cnt_rst_n(cnt_rst_n), .cnt_enable(cnt_enable), .cnt_flip(cnt_flip),
    .cnt_max(cnt_max), .cnt_min(cnt_min), .seg_idx(seg_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  en_cnt   = 0;
  int  flip_cnt = 0;
  int  flip_cyc = -1;
  bit  mon_on   = 1'b0;
  bit  busy_q   = 1'b0;
  bit  end_seen = 1'b0;
  bit  rec_on   = 1'b0;
  ev_t exp_q[$];
  int  got_seq[$];

  int  t_max  [NUM_SEG];
  int  t_min  [NUM_SEG];
  int  t_len  [NUM_SEG];
  bit  t_last [NUM_SEG];

  int  m_out = 0;
  bit  m_up  = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic sb_pop(input int kind, input int a, input int b, input int c);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", kind, e.kind);
      check(e.kind == EV_LOAD ? "load_seg_idx" : "end_enable_count", a, e.a);
      check(e.kind == EV_LOAD ? "load_max"     : "end_flip_count",   b, e.b);
      check(e.kind == EV_LOAD ? "load_min"     : "end_err",          c, e.c);
    end
  endtask

  always @(posedge clk) cyc++;

  // Behavioural ping-pong counter driven by the sequencer outputs.
  always @(posedge clk) begin
    if (!cnt_rst_n) begin
      m_out = int'(cnt_min);
      m_up  = 1'b1;
    end else if (cnt_enable) begin
      if (cnt_flip) m_up = !m_up;
      if (m_up) begin
        if (m_out >= int'(cnt_max)) begin m_up = 1'b0; m_out--; end
        else m_out++;
      end else begin
        if (m_out <= int'(cnt_min)) begin m_up = 1'b1; m_out++; end
        else m_out--;
      end
    end
    if (rec_on && (!cnt_rst_n || cnt_enable)) got_seq.push_back(m_out);
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (cnt_enable) en_cnt++;
      if (cnt_flip) begin
        flip_cnt++;
        flip_cyc = cyc;
        check("flip_with_enable", cnt_enable, 1);
      end
      if (!cnt_rst_n && busy) sb_pop(EV_LOAD, int'(seg_idx), int'(cnt_max), int'(cnt_min));
      if (done) begin
        sb_pop(EV_DONE, en_cnt, flip_cnt, int'(err));
        end_seen = 1'b1;
      end else if (busy_q && !busy) begin
        check("abort_enable_low", cnt_enable, 0);
        sb_pop(EV_ABORT, en_cnt, flip_cnt, int'(err));
        end_seen = 1'b1;
      end
      busy_q = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_SEG; i++) begin
      t_max[i] = 0; t_min[i] = 0; t_len[i] = 0; t_last[i] = 1'b1;
    end
  endtask

  task automatic write_seg(input int idx, input int mx, input int mn, input int len, input bit last);
    cfg_we   = 1'b1;
    cfg_addr = ADDR_W'(idx);
    cfg_max  = 4'(mx);
    cfg_min  = 4'(mn);
    cfg_len  = LEN_W'(len);
    cfg_last = last;
    tick();
    cfg_we = 1'b0;
    t_max[idx] = mx; t_min[idx] = mn; t_len[idx] = len; t_last[idx] = last;
  endtask

  // Walks the reference table exactly as the program should execute.
  task automatic expect_program(input int flips);
    int tot = 0;
    bit e   = 1'b0;
    for (int i = 0; i < NUM_SEG; i++) begin
      exp_q.push_back('{EV_LOAD, i, t_max[i], t_min[i]});
      if (t_max[i] <= t_min[i]) e = 1'b1;
      else tot += t_len[i];
      if (t_last[i]) break;
    end
    exp_q.push_back('{EV_DONE, tot, flips, int'(e)});
  endtask

  task automatic begin_run();
    en_cnt   = 0;
    flip_cnt = 0;
    flip_cyc = -1;
    end_seen = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    for (int k = 0; k < budget && !end_seen; k++) tick();
    check("end_within_budget", end_seen, 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq1[7] = '{2, 3, 4, 5, 4, 3, 2};
    int c0;
    int rel;

    clear_model();
    #2 rst = 1'b1;
    tick(); tick();
    check("rst_cnt_rst_n", cnt_rst_n, 0);
    check("rst_cnt_enable", cnt_enable, 0);
    check("rst_cnt_flip", cnt_flip, 0);
    check("rst_cnt_max", cnt_max, 0);
    check("rst_cnt_min", cnt_min, 0);
    check("rst_seg_idx", seg_idx, 0);
    check("rst_busy_done_err", {busy, done, err}, 0);
    #3 rst = 1'b0;
    tick();
    check("idle_cnt_rst_n", cnt_rst_n, 1);
    mon_on = 1'b1;

    // Single segment: counter traces 2,3,4,5,4,3,2.
    write_seg(0, 5, 2, 6, 1'b1);
    expect_program(0);
    got_seq.delete();
    rec_on = 1'b1;
    begin_run();
    wait_end(50);
    rec_on = 1'b0;
    check("seq1_len", got_seq.size(), 7);
    for (int i = 0; i < 7 && i < got_seq.size(); i++) check("seq1_value", got_seq[i], seq1[i]);

    // Two segments chained.
    write_seg(0, 3, 0, 4, 1'b0);
    write_seg(1, 9, 6, 3, 1'b1);
    expect_program(0);
    begin_run();
    wait_end(50);

    // Flip request in the second RUN cycle.
    write_seg(0, 7, 0, 5, 1'b1);
    expect_program(1);
    begin_run();
    c0 = cyc;
    tick(); tick();
    flip_req = 1'b1;
    tick();
    flip_req = 1'b0;
    wait_end(50);
    check("flip_cycle", flip_cyc, c0 + 3);

    // Same, with pause held for three cycles: the flip waits for release.
    expect_program(1);
    begin_run();
    tick(); tick();
    flip_req = 1'b1;
    pause    = 1'b1;
    tick();
    flip_req = 1'b0;
    tick(); tick();
    pause = 1'b0;
    rel   = cyc;
    wait_end(50);
    check("flip_deferred_cycle", flip_cyc, rel + 1);

    // Degenerate bounds and zero length: both skipped, err raised.
    write_seg(0, 4, 4, 3, 1'b0);
    write_seg(1, 8, 1, 0, 1'b1);
    expect_program(0);
    begin_run();
    wait_end(50);

    // Program without a last marker stops at the final table entry.
    write_seg(0, 3, 0, 1, 1'b0);
    write_seg(1, 3, 0, 1, 1'b0);
    write_seg(2, 3, 0, 1, 1'b0);
    write_seg(3, 3, 0, 2, 1'b0);
    expect_program(0);
    begin_run();
    wait_end(50);

    // Abort mid-RUN, then restart from segment 0.
    write_seg(0, 9, 0, 20, 1'b1);
    exp_q.push_back('{EV_LOAD, 0, 9, 0});
    exp_q.push_back('{EV_ABORT, 3, 0, 0});
    begin_run();
    tick(); tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_end(10);
    check("abort_busy", busy, 0);
    write_seg(0, 6, 1, 2, 1'b1);
    expect_program(0);
    begin_run();
    wait_end(50);

    // start and abort together in IDLE: nothing starts.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick(); tick();
    check("start_abort_idle_busy", busy, 0);

    // Asynchronous reset mid-RUN.
    write_seg(0, 9, 0, 20, 1'b1);
    exp_q.push_back('{EV_LOAD, 0, 9, 0});
    begin_run();
    tick(); tick(); tick();
    mon_on = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("async_rst_cnt_rst_n", cnt_rst_n, 0);
    check("async_rst_cnt_enable", cnt_enable, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_cnt_max", cnt_max, 0);
    #2 rst = 1'b0;
    clear_model();
    tick(); tick();
    check("post_rst_cnt_rst_n", cnt_rst_n, 1);
    check("post_rst_busy", busy, 0);
    busy_q = 1'b0;
    mon_on = 1'b1;
    expect_program(0);
    begin_run();
    wait_end(50);

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
